// File: rtl/dll_ack_nack_gen.sv
// Receive-side data link layer Ack/Nak generator: classifies each incoming TLP
// by sequence number and CRC status, tracks NEXT_RCV_SEQ and schedules Ack/Nak DLLPs.
module dll_ack_nack_gen #(
    parameter int SEQ_W        = 12,
    parameter int ACK_COALESCE = 4,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tlp_valid,
    input  logic [SEQ_W-1:0] tlp_seq,
    input  logic             tlp_crc_ok,
    output logic             tlp_accept,
    output logic             tlp_drop,
    output logic             dllp_valid,
    input  logic             dllp_ready,
    output logic [2:0]       ack_nack,
    output logic [SEQ_W-1:0] seq,
    output logic [SEQ_W-1:0] next_rcv_seq
);

    localparam int CNT_W = $clog2(ACK_COALESCE + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] COAL_MAX = CNT_W'(ACK_COALESCE);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_NAK = 2'd1,
        SEND_ACK = 2'd2
    } state_t;

    state_t           state, state_n;

    logic             nak_scheduled, nak_scheduled_n;
    logic             nak_req, nak_req_n;
    logic             ack_req, ack_req_n;
    logic             ack_pending, ack_pending_n;
    logic [CNT_W-1:0] coal_cnt, coal_cnt_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [SEQ_W-1:0] next_rcv_seq_n;
    logic [SEQ_W-1:0] seq_q;
    logic             accept_p1, drop_p1;

    logic [SEQ_W-1:0] d;
    logic [SEQ_W-1:0] nrs_m1;
    logic             is_bad, is_good, is_dup, is_gap;
    logic             hs_ack, hs_nak, hs_any, covered;
    logic             ack_trig;

    function automatic logic [CNT_W-1:0] coal_sat_inc(input logic [CNT_W-1:0] c);
        return (c == COAL_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] t);
        return (t == TMR_MAX) ? t : t + 1'b1;
    endfunction

    // Stage p0: classify the arriving TLP against the pre-update NEXT_RCV_SEQ
    always_comb begin
        d       = next_rcv_seq - tlp_seq;
        nrs_m1  = next_rcv_seq - 1'b1;
        is_bad  = tlp_valid && !tlp_crc_ok;
        is_good = tlp_valid && tlp_crc_ok && (d == '0);
        // 1 <= d <= 2^(SEQ_W-1): either MSB clear, or exactly the half-range value
        is_dup  = tlp_valid && tlp_crc_ok && (d != '0) &&
                  (!d[SEQ_W-1] || (d[SEQ_W-2:0] == '0));
        is_gap  = tlp_valid && tlp_crc_ok && !is_good && !is_dup;
    end

    always_comb begin
        hs_ack  = (state == SEND_ACK) && dllp_ready;
        hs_nak  = (state == SEND_NAK) && dllp_ready;
        hs_any  = hs_ack || hs_nak;
        // The DLLP only retires ack_pending if nothing was accepted after its seq was latched
        covered = (seq_q == nrs_m1);
        ack_trig = ack_req ||
                   (ack_pending && ((coal_cnt >= COAL_MAX) || (timer >= TMR_MAX)));
    end

    always_comb begin
        next_rcv_seq_n  = next_rcv_seq;
        nak_scheduled_n = nak_scheduled;
        nak_req_n       = nak_req;
        ack_req_n       = ack_req;
        ack_pending_n   = ack_pending;
        coal_cnt_n      = coal_cnt;
        timer_n         = timer;

        if (ack_pending)
            timer_n = tmr_sat_inc(timer);

        // Handshake clears first so that requests from a same-cycle TLP survive
        if (hs_nak)
            nak_req_n = 1'b0;
        if (hs_ack)
            ack_req_n = 1'b0;
        if (hs_any) begin
            coal_cnt_n = '0;
            timer_n    = '0;
            if (covered)
                ack_pending_n = 1'b0;
        end

        if (is_good) begin
            next_rcv_seq_n  = next_rcv_seq + 1'b1;
            nak_scheduled_n = 1'b0;
            ack_pending_n   = 1'b1;
            coal_cnt_n      = coal_sat_inc(coal_cnt_n);
        end
        if ((is_bad || is_gap) && !nak_scheduled) begin
            nak_scheduled_n = 1'b1;
            nak_req_n       = 1'b1;
        end
        if (is_dup)
            ack_req_n = 1'b1;
    end

    // Stage p1: tracking state and registered accept/drop pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            next_rcv_seq  <= '0;
            nak_scheduled <= 1'b0;
            nak_req       <= 1'b0;
            ack_req       <= 1'b0;
            ack_pending   <= 1'b0;
            coal_cnt      <= '0;
            timer         <= '0;
            accept_p1     <= 1'b0;
            drop_p1       <= 1'b0;
            seq_q         <= '0;
        end else begin
            next_rcv_seq  <= next_rcv_seq_n;
            nak_scheduled <= nak_scheduled_n;
            nak_req       <= nak_req_n;
            ack_req       <= ack_req_n;
            ack_pending   <= ack_pending_n;
            coal_cnt      <= coal_cnt_n;
            timer         <= timer_n;
            accept_p1     <= is_good;
            drop_p1       <= is_bad || is_dup || is_gap;
            if ((state == IDLE) && (state_n != IDLE))
                seq_q <= nrs_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (nak_req)
                    state_n = SEND_NAK;
                else if (ack_trig)
                    state_n = SEND_ACK;
            end
            SEND_NAK: if (dllp_ready) state_n = IDLE;
            SEND_ACK: if (dllp_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        dllp_valid = 1'b0;
        ack_nack   = 3'b000;
        case (state)
            SEND_NAK: begin
                dllp_valid = 1'b1;
                ack_nack   = 3'b010;
            end
            SEND_ACK: begin
                dllp_valid = 1'b1;
                ack_nack   = 3'b001;
            end
            default: ;
        endcase
    end

    assign seq        = seq_q;
    assign tlp_accept = accept_p1;
    assign tlp_drop   = drop_p1;

endmodule

// File: tb/tb_dll_ack_nack_gen.sv
// Directed bench for dll_ack_nack_gen: ordered, duplicate, gap, bad-CRC, wrap,
// timeout and back-pressure scenarios with hand-computed expectations.
module tb_dll_ack_nack_gen;

    logic        clk;
    logic        reset;
    logic        tlp_valid;
    logic [11:0] tlp_seq;
    logic        tlp_crc_ok;
    logic        tlp_accept;
    logic        tlp_drop;
    logic        dllp_valid;
    logic        dllp_ready;
    logic [2:0]  ack_nack;
    logic [11:0] seq;
    logic [11:0] next_rcv_seq;

    int n_cmp = 0;
    int n_err = 0;

    int n_ack = 0, n_nak = 0, n_acc = 0, n_drop = 0;
    logic [2:0]  last_an = 3'b000;
    logic [11:0] last_seq = 12'd0;

    int a_ack, a_nak, a_acc, a_drop;
    int first_k;
    logic [11:0] got_seq;
    logic [2:0]  got_an;
    logic        found;

    dll_ack_nack_gen #(
        .SEQ_W(12),
        .ACK_COALESCE(4),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tlp_valid(tlp_valid),
        .tlp_seq(tlp_seq),
        .tlp_crc_ok(tlp_crc_ok),
        .tlp_accept(tlp_accept),
        .tlp_drop(tlp_drop),
        .dllp_valid(dllp_valid),
        .dllp_ready(dllp_ready),
        .ack_nack(ack_nack),
        .seq(seq),
        .next_rcv_seq(next_rcv_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes and pulses are recorded on the falling edge, between updates
    always @(negedge clk) begin
        if (dllp_valid && dllp_ready) begin
            if (ack_nack == 3'b001) n_ack <= n_ack + 1;
            if (ack_nack == 3'b010) n_nak <= n_nak + 1;
            last_an  <= ack_nack;
            last_seq <= seq;
        end
        if (tlp_accept) n_acc <= n_acc + 1;
        if (tlp_drop)   n_drop <= n_drop + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_tlp(input logic [11:0] s, input logic ok);
        tlp_valid  = 1'b1;
        tlp_seq    = s;
        tlp_crc_ok = ok;
        tick();
        tlp_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic snap();
        a_ack  = n_ack;
        a_nak  = n_nak;
        a_acc  = n_acc;
        a_drop = n_drop;
    endtask

    initial begin
        reset      = 1'b1;
        tlp_valid  = 1'b0;
        tlp_seq    = 12'd0;
        tlp_crc_ok = 1'b0;
        dllp_ready = 1'b1;
        ticks(3);
        reset = 1'b0;

        check("rst_next_rcv_seq", 32'(next_rcv_seq), 32'd0);
        check("rst_dllp_valid",   32'(dllp_valid),   32'd0);
        check("rst_ack_nack",     32'(ack_nack),     32'd0);
        check("rst_seq",          32'(seq),          32'd0);
        check("rst_tlp_accept",   32'(tlp_accept),   32'd0);
        check("rst_tlp_drop",     32'(tlp_drop),     32'd0);

        // Four in-order TLPs: coalesced into a single Ack for seq 3
        snap();
        send_tlp(12'd0, 1'b1);
        check("accept_latency", 32'(tlp_accept), 32'd1);
        send_tlp(12'd1, 1'b1);
        send_tlp(12'd2, 1'b1);
        send_tlp(12'd3, 1'b1);
        check("nrs_after_4", 32'(next_rcv_seq), 32'd4);
        ticks(6);
        check("coal_accepts", 32'(n_acc - a_acc), 32'd4);
        check("coal_ack_cnt", 32'(n_ack - a_ack), 32'd1);
        check("coal_ack_seq", 32'(last_seq), 32'd3);
        check("coal_ack_kind", 32'(last_an), 32'd1);
        check("coal_no_nak", 32'(n_nak - a_nak), 32'd0);

        // Single TLP: Ack only on timeout
        do_reset();
        snap();
        send_tlp(12'd0, 1'b1);
        first_k = 0;
        got_seq = 12'd0;
        got_an  = 3'b000;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (dllp_valid && (first_k == 0)) begin
                first_k = k;
                got_seq = seq;
                got_an  = ack_nack;
            end
        end
        check("timeout_rise_cycle", 32'(first_k), 32'd65);
        check("timeout_ack_kind", 32'(got_an), 32'd1);
        check("timeout_ack_seq", 32'(got_seq), 32'd0);
        check("timeout_ack_cnt", 32'(n_ack - a_ack), 32'd1);

        // GAP then bad CRC: one Nak, then an in-order TLP clears the Nak state
        do_reset();
        for (int i = 0; i < 5; i++) send_tlp(12'(i), 1'b1);
        ticks(100);
        check("gap_pre_nrs", 32'(next_rcv_seq), 32'd5);
        snap();
        send_tlp(12'd7, 1'b1);
        check("gap_drop", 32'(tlp_drop), 32'd1);
        tick();
        check("gap_nak_valid", 32'(dllp_valid), 32'd1);
        check("gap_nak_kind", 32'(ack_nack), 32'd2);
        check("gap_nak_seq", 32'(seq), 32'd4);
        send_tlp(12'd5, 1'b0);
        ticks(5);
        check("bad_drop_cnt", 32'(n_drop - a_drop), 32'd2);
        check("bad_single_nak", 32'(n_nak - a_nak), 32'd1);
        send_tlp(12'd5, 1'b1);
        check("recover_accept", 32'(tlp_accept), 32'd1);
        check("recover_nrs", 32'(next_rcv_seq), 32'd6);
        send_tlp(12'd9, 1'b1);
        ticks(5);
        check("renak_cnt", 32'(n_nak - a_nak), 32'd2);
        check("renak_seq", 32'(last_seq), 32'd5);
        check("renak_no_ack", 32'(n_ack - a_ack), 32'd0);

        // Duplicate TLP forces an immediate Ack
        do_reset();
        for (int i = 0; i < 10; i++) send_tlp(12'(i), 1'b1);
        ticks(100);
        snap();
        send_tlp(12'd8, 1'b1);
        check("dup_drop", 32'(tlp_drop), 32'd1);
        tick();
        check("dup_ack_valid", 32'(dllp_valid), 32'd1);
        check("dup_ack_kind", 32'(ack_nack), 32'd1);
        check("dup_ack_seq", 32'(seq), 32'd9);
        check("dup_nrs", 32'(next_rcv_seq), 32'd10);
        check("dup_no_accept", 32'(n_acc - a_acc), 32'd0);
        ticks(3);

        // Sequence wrap 4095 -> 0
        do_reset();
        for (int i = 0; i < 4095; i++) send_tlp(12'(i), 1'b1);
        ticks(100);
        check("wrap_pre_nrs", 32'(next_rcv_seq), 32'd4095);
        snap();
        send_tlp(12'd4095, 1'b1);
        send_tlp(12'd0, 1'b1);
        ticks(100);
        check("wrap_accepts", 32'(n_acc - a_acc), 32'd2);
        check("wrap_nrs", 32'(next_rcv_seq), 32'd1);
        check("wrap_ack_seq", 32'(last_seq), 32'd0);
        check("wrap_ack_kind", 32'(last_an), 32'd1);
        send_tlp(12'd4095, 1'b1);
        check("wrap_dup_drop", 32'(tlp_drop), 32'd1);
        tick();
        check("wrap_dup_ack", 32'({dllp_valid, ack_nack, seq}), 32'({1'b1, 3'b001, 12'd0}));
        ticks(3);

        // Nak held under back-pressure while a good TLP arrives
        do_reset();
        dllp_ready = 1'b0;
        send_tlp(12'd5, 1'b1);
        tick();
        check("hold_nak_kind", 32'(ack_nack), 32'd2);
        check("hold_nak_seq", 32'(seq), 32'd4095);
        send_tlp(12'd0, 1'b1);
        check("hold_good_accept", 32'(tlp_accept), 32'd1);
        for (int i = 0; i < 9; i++) begin
            check("hold_stable", 32'({dllp_valid, ack_nack, seq}), 32'({1'b1, 3'b010, 12'hFFF}));
            tick();
        end
        check("hold_nrs", 32'(next_rcv_seq), 32'd1);
        dllp_ready = 1'b1;
        tick();
        found   = 1'b0;
        got_seq = 12'hABC;
        for (int k = 0; k < 100; k++) begin
            if (!found && dllp_valid && (ack_nack == 3'b001)) begin
                found   = 1'b1;
                got_seq = seq;
            end
            if (!found) tick();
        end
        check("post_hold_ack_found", 32'(found), 32'd1);
        check("post_hold_ack_seq", 32'(got_seq), 32'd0);
        ticks(2);

        // Reset while a Nak is stalled abandons it and clears all state
        dllp_ready = 1'b0;
        send_tlp(12'd9, 1'b1);
        tick();
        check("stall_nak", 32'({dllp_valid, ack_nack, seq}), 32'({1'b1, 3'b010, 12'd0}));
        ticks(3);
        reset = 1'b1;
        tick();
        check("midrst_dllp_valid", 32'(dllp_valid), 32'd0);
        check("midrst_ack_nack", 32'(ack_nack), 32'd0);
        check("midrst_seq", 32'(seq), 32'd0);
        check("midrst_nrs", 32'(next_rcv_seq), 32'd0);
        check("midrst_pulses", 32'({tlp_accept, tlp_drop}), 32'd0);
        reset = 1'b0;
        dllp_ready = 1'b1;
        snap();
        send_tlp(12'd3, 1'b1);
        tick();
        check("postrst_nak", 32'({dllp_valid, ack_nack, seq}), 32'({1'b1, 3'b010, 12'hFFF}));
        ticks(3);
        check("postrst_nak_cnt", 32'(n_nak - a_nak), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dll_ack_nack_gen.md
Name: dll_ack_nack_gen

Overview:
- Receive-side data link layer block; the far-end partner of the transmit replay buffer.
- Checks each incoming TLP's 12-bit sequence number and CRC status, and forwards in-order good TLPs to the transaction layer.
- Tracks NEXT_RCV_SEQ and schedules Ack/Nak DLLPs back toward the link partner's replay buffer, using the same ack_nack encoding and 12-bit seq field that buffer consumes.

Parameters:
- SEQ_W, 12, sequence number width; arithmetic is modulo 2^SEQ_W.
- ACK_COALESCE, 4, number of accepted TLPs that forces an immediate Ack.
- ACK_TIMEOUT, 64, cycles from the first unacknowledged accepted TLP to a forced Ack; must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- tlp_valid  in  1  one-cycle strobe at the end of a received TLP.
- tlp_seq  in  SEQ_W  sequence number of that TLP.
- tlp_crc_ok  in  1  LCRC check passed; sampled with tlp_valid.
- tlp_accept  out  1  one-cycle pulse: TLP delivered upward (good and in sequence).
- tlp_drop  out  1  one-cycle pulse: TLP discarded.
- dllp_valid  out  1  Ack/Nak DLLP request.
- dllp_ready  in  1  transmit arbiter takes the DLLP when dllp_valid && dllp_ready.
- ack_nack  out  3  3'b001 = Ack, 3'b010 = Nak, 3'b000 = none (value when dllp_valid = 0).
- seq  out  SEQ_W  AckNak_Seq_Num carried by the DLLP.
- next_rcv_seq  out  SEQ_W  current expected sequence number (status).

Behaviour:
- Reset values: next_rcv_seq = 0, nak_scheduled = 0, ack_pending = 0, coalesce count = 0, timer = 0, dllp_valid = 0, ack_nack = 0, seq = 0, tlp_accept = 0, tlp_drop = 0. An outstanding DLLP is abandoned on reset.
- Classification on a tlp_valid cycle, with d = (next_rcv_seq − tlp_seq) mod 2^SEQ_W:
  - BAD: tlp_crc_ok = 0. Assert tlp_drop. If nak_scheduled = 0, set nak_scheduled and nak_req.
  - GOOD: crc ok and d = 0. Assert tlp_accept. Increment next_rcv_seq (wrap 4095 → 0). Clear nak_scheduled. Set ack_pending and increment the coalesce count.
  - DUP: crc ok and 1 ≤ d ≤ 2^(SEQ_W−1). Assert tlp_drop. Set ack_req (immediate Ack).
  - GAP: crc ok and any other d. Assert tlp_drop. Same Nak rule as BAD.
- tlp_accept and tlp_drop are registered: they assert 1 cycle after tlp_valid. next_rcv_seq updates on the same edge.
- Ack trigger: ack_req, or (ack_pending and coalesce count ≥ ACK_COALESCE), or (ack_pending and timer reaches ACK_TIMEOUT).
- Timer: starts at 0 when ack_pending goes 0 → 1, increments each cycle while ack_pending = 1, and clears when an Ack handshake completes.
- FSM states:
  - IDLE: nak_req → SEND_NAK; otherwise an Ack trigger → SEND_ACK. Nak has priority over Ack.
  - SEND_NAK: dllp_valid = 1, ack_nack = 010.
  - SEND_ACK: dllp_valid = 1, ack_nack = 001.
  - On entry to SEND_NAK or SEND_ACK, latch seq = next_rcv_seq − 1 mod 2^SEQ_W, so the first value after reset is 4095.
  - Hold ack_nack and seq stable while dllp_valid && !dllp_ready, even if further TLPs arrive.
  - On handshake: return to IDLE. A Nak clears nak_req. An Ack clears ack_req, ack_pending, the coalesce count and the timer. A completed Nak also clears ack_pending, because a Nak acknowledges all seq ≤ its seq.
  - Any requests raised during the SEND state are retained and serviced from IDLE, earliest on the cycle after the handshake. dllp_valid therefore drops for at least 1 cycle between DLLPs.
- Simultaneous events:
  - tlp_valid in the same cycle as a handshake: classification uses the pre-update next_rcv_seq. Requests raised by that TLP survive the clear performed by the handshake.
  - A GOOD TLP while in SEND_NAK still increments next_rcv_seq; the in-flight Nak keeps its latched seq.
- Minimum latency: tlp_valid → dllp_valid is 2 cycles (classification register, then FSM entry).

Test Plan:
- After reset, good TLPs seq 0,1,2,3 on consecutive cycles, dllp_ready = 1 → four tlp_accept pulses; one Ack with seq = 3; next_rcv_seq = 4.
- One good TLP seq 0, then idle, ACK_TIMEOUT = 64 → Ack with seq = 0 asserted 64 cycles (±1 for pipeline) after the TLP; no Ack before that.
- next_rcv_seq = 5; TLP seq 7 (GAP) → tlp_drop, Nak seq = 4. A following bad-CRC TLP → tlp_drop, no second Nak. Then good seq 5 → accept; nak_scheduled cleared.
- next_rcv_seq = 10; good TLP seq 8 (DUP) → tlp_drop, immediate Ack seq = 9; next_rcv_seq stays 10.
- Wrap: set next_rcv_seq = 4095 via a TLP stream; good seq 4095 then seq 0 → both accepted; next_rcv_seq = 1; Ack seq = 0. A DUP with seq 4095 at next_rcv_seq = 1 → Ack seq = 0.
- Nak pending with dllp_ready = 0 for 10 cycles while good seq N arrives → ack_nack = 010 and seq held constant throughout. After ready, an Ack for seq N follows. Assert reset mid-hold → dllp_valid = 0 the next cycle and all state zeroed.
